// File: rtl/mod_counter_bcd.sv
// Modulo-N up/down counter with parallel BCD digits, synchronous preset and
// a registered one-cycle carry/borrow pulse for cascading clock stages.
module mod_counter_bcd #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60,
  parameter int MIN_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q_out,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             carry_out,
  output logic             load_err
);
  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;
  localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [3:0]       tens;
    logic [3:0]       ones;
  } cnt_t;

  localparam cnt_t CNT_MIN = {MIN_Q, MIN_T, MIN_O};
  localparam cnt_t CNT_MAX = {MAX_Q, MAX_T, MAX_O};

  cnt_t cur, nxt;
  logic carry_nxt, err_nxt, ld_ok, q_bad;

  // Only ever applied to in-range values, so the 7-bit view covers 0..99.
  function automatic cnt_t to_cnt(input logic [WIDTH-1:0] v);
    cnt_t       r;
    logic [6:0] b;
    b      = 7'(v);
    r.q    = v;
    r.tens = 4'(b / 7'd10);
    r.ones = 4'(b % 7'd10);
    return r;
  endfunction

  // MIN_VAL is 0 or 1, so "below range" can only mean value 0 with a 1-based range.
  assign ld_ok = (load_value <= MAX_Q) && !((MIN_VAL != 0) && (load_value == '0));
  assign q_bad = (cur.q > MAX_Q) || ((MIN_VAL != 0) && (cur.q == '0));

  always_comb begin
    nxt       = cur;
    carry_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if (ld_ok) begin
        nxt = to_cnt(load_value);
      end else begin
        nxt     = CNT_MIN;
        err_nxt = 1'b1;
      end
    end else if (q_bad) begin
      nxt = CNT_MIN;
    end else if (enable) begin
      if (up_down) begin
        if (cur.q == MAX_Q) begin
          nxt       = CNT_MIN;
          carry_nxt = 1'b1;
        end else begin
          nxt.q = cur.q + WIDTH'(1);
          if (cur.ones == 4'd9) begin
            nxt.ones = 4'd0;
            nxt.tens = cur.tens + 4'd1;
          end else begin
            nxt.ones = cur.ones + 4'd1;
          end
        end
      end else begin
        if (cur.q == MIN_Q) begin
          nxt       = CNT_MAX;
          carry_nxt = 1'b1;
        end else begin
          nxt.q = cur.q - WIDTH'(1);
          if (cur.ones == 4'd0) begin
            nxt.ones = 4'd9;
            nxt.tens = cur.tens - 4'd1;
          end else begin
            nxt.ones = cur.ones - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= CNT_MIN;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cur       <= nxt;
      carry_out <= carry_nxt;
      load_err  <= err_nxt;
    end
  end

  assign q_out    = cur.q;
  assign bcd_tens = cur.tens;
  assign bcd_ones = cur.ones;
endmodule

// File: tb/tb_mod_counter_bcd.sv
// Bench for mod_counter_bcd: mod-60, 1..12 and a sec->min cascade, checked
// against vector tables and an arithmetic reference model.
module tb_mod_counter_bcd;
  logic clock;
  int   n_chk, n_fail;

  // Mod-60, 0-based instance
  logic       a_rst, a_en, a_ud, a_ld;
  logic [5:0] a_lv, a_q;
  logic [3:0] a_t, a_o;
  logic       a_c, a_e;
  int         ma;

  // 1..12 instance
  logic       b_rst, b_en, b_ud, b_ld;
  logic [3:0] b_lv, b_q;
  logic [3:0] b_t, b_o;
  logic       b_c, b_e;
  int         mb;

  // Cascade sec -> min
  logic       c_rst, c_en, c_zero, c_one;
  logic [5:0] c_lv, s_q, m_q;
  logic [3:0] s_t, s_o, m_t, m_o;
  logic       s_c, s_e, m_c, m_e;

  mod_counter_bcd u_a (.clock(clock), .reset(a_rst), .enable(a_en), .up_down(a_ud),
    .load(a_ld), .load_value(a_lv), .q_out(a_q), .bcd_tens(a_t), .bcd_ones(a_o),
    .carry_out(a_c), .load_err(a_e));

  mod_counter_bcd #(.WIDTH(4), .MODULUS(12), .MIN_VAL(1)) u_b (.clock(clock), .reset(b_rst),
    .enable(b_en), .up_down(b_ud), .load(b_ld), .load_value(b_lv), .q_out(b_q),
    .bcd_tens(b_t), .bcd_ones(b_o), .carry_out(b_c), .load_err(b_e));

  mod_counter_bcd u_sec (.clock(clock), .reset(c_rst), .enable(c_en), .up_down(c_one),
    .load(c_zero), .load_value(c_lv), .q_out(s_q), .bcd_tens(s_t), .bcd_ones(s_o),
    .carry_out(s_c), .load_err(s_e));

  mod_counter_bcd u_min (.clock(clock), .reset(c_rst), .enable(s_c), .up_down(c_one),
    .load(c_zero), .load_value(c_lv), .q_out(m_q), .bcd_tens(m_t), .bcd_ones(m_o),
    .carry_out(m_c), .load_err(m_e));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: position within the range, advanced modulo MODULUS.
  task automatic ref_step(input int mn, input int md, input bit rst, input bit en,
                          input bit ud, input bit ld, input int lv,
                          inout int m, output bit c, output bit e);
    int off;
    c = 1'b0;
    e = 1'b0;
    if (rst) m = mn;
    else if (ld) begin
      if (lv >= mn && lv <= mn + md - 1) m = lv;
      else begin
        m = mn;
        e = 1'b1;
      end
    end else if (en) begin
      off = m - mn;
      if (ud) begin
        c   = (off == md - 1);
        off = (off + 1) % md;
      end else begin
        c   = (off == 0);
        off = (off + md - 1) % md;
      end
      m = mn + off;
    end
  endtask

  task automatic drive_a(input bit rst, input bit en, input bit ud, input bit ld, input int lv);
    bit c, e;
    a_rst = rst; a_en = en; a_ud = ud; a_ld = ld; a_lv = 6'(lv);
    @(posedge clock); #1;
    ref_step(0, 60, rst, en, ud, ld, lv, ma, c, e);
    chk("a_q", int'(a_q), ma);
    chk("a_tens", int'(a_t), ma / 10);
    chk("a_ones", int'(a_o), ma % 10);
    chk("a_carry", int'(a_c), int'(c));
    chk("a_load_err", int'(a_e), int'(e));
    a_rst = 1'b0; a_en = 1'b0; a_ld = 1'b0;
  endtask

  task automatic drive_b(input bit rst, input bit en, input bit ud, input bit ld, input int lv);
    bit c, e;
    b_rst = rst; b_en = en; b_ud = ud; b_ld = ld; b_lv = 4'(lv);
    @(posedge clock); #1;
    ref_step(1, 12, rst, en, ud, ld, lv, mb, c, e);
    chk("b_q", int'(b_q), mb);
    chk("b_tens", int'(b_t), mb / 10);
    chk("b_ones", int'(b_o), mb % 10);
    chk("b_carry", int'(b_c), int'(c));
    chk("b_load_err", int'(b_e), int'(e));
    b_rst = 1'b0; b_en = 1'b0; b_ld = 1'b0;
  endtask

  typedef struct {
    bit rst, en, ud, ld;
    int lv;
    int q;
    bit c, e;
  } vec_t;

  vec_t tbl[21];

  initial begin
    n_chk = 0; n_fail = 0; ma = 0; mb = 1;
    a_rst = 0; a_en = 0; a_ud = 1; a_ld = 0; a_lv = '0;
    b_rst = 0; b_en = 0; b_ud = 1; b_ld = 0; b_lv = '0;
    c_rst = 1; c_en = 0; c_zero = 0; c_one = 1; c_lv = '0;

    //          rst en ud ld  lv   q  c  e
    tbl[0]  = '{1, 0, 1, 0,  0,  0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0,  0,  1, 0, 0};
    tbl[2]  = '{0, 1, 1, 0,  0,  2, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 45, 45, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 63,  0, 0, 1};
    tbl[5]  = '{0, 0, 1, 0,  0,  0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0,  0, 59, 1, 0};
    tbl[7]  = '{0, 1, 0, 0,  0, 58, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 59, 59, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 30,  0, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 59, 59, 0, 0};
    tbl[11] = '{0, 1, 1, 0,  0,  0, 1, 0};
    tbl[12] = '{0, 1, 1, 0,  0,  1, 0, 0};
    tbl[13] = '{0, 0, 1, 1,  0,  0, 0, 0};
    tbl[14] = '{0, 0, 1, 1, 60,  0, 0, 1};
    tbl[15] = '{0, 0, 1, 1, 10, 10, 0, 0};
    tbl[16] = '{0, 0, 1, 0,  0, 10, 0, 0};
    tbl[17] = '{0, 1, 1, 0,  0, 11, 0, 0};
    tbl[18] = '{0, 0, 0, 0,  0, 11, 0, 0};
    tbl[19] = '{0, 1, 0, 0,  0, 10, 0, 0};
    tbl[20] = '{0, 0, 1, 0,  0, 10, 0, 0};

    for (int i = 0; i < 21; i++) begin
      drive_a(tbl[i].rst, tbl[i].en, tbl[i].ud, tbl[i].ld, tbl[i].lv);
      chk($sformatf("tbl%0d_q", i), int'(a_q), tbl[i].q);
      chk($sformatf("tbl%0d_carry", i), int'(a_c), int'(tbl[i].c));
      chk($sformatf("tbl%0d_err", i), int'(a_e), int'(tbl[i].e));
    end

    // Full mod-60 lap from reset
    drive_a(1, 0, 1, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      drive_a(0, 1, 1, 0, 0);
      if (i == 59) begin
        chk("lap_q59", int'(a_q), 59);
        chk("lap_tens59", int'(a_t), 5);
        chk("lap_ones59", int'(a_o), 9);
      end
      if (i == 60) begin
        chk("lap_wrap_q", int'(a_q), 0);
        chk("lap_wrap_carry", int'(a_c), 1);
      end
    end

    // Randomized mod-60 traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive_a(r < 3, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              r >= 3 && r < 15, int'($urandom_range(0, 63)));
    end

    // 1-based borrow
    drive_b(1, 0, 0, 0, 0);
    chk("b_reset_q", int'(b_q), 1);
    drive_b(0, 1, 0, 0, 0);
    chk("b_borrow_q", int'(b_q), 12);
    chk("b_borrow_carry", int'(b_c), 1);
    chk("b_borrow_tens", int'(b_t), 1);
    chk("b_borrow_ones", int'(b_o), 2);
    drive_b(0, 1, 0, 0, 0);
    chk("b_after_q", int'(b_q), 11);
    chk("b_after_carry", int'(b_c), 0);
    drive_b(0, 0, 1, 1, 0);
    chk("b_load0_err", int'(b_e), 1);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive_b(r < 3, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              r >= 3 && r < 15, int'($urandom_range(0, 15)));
    end

    // Seconds -> minutes cascade
    c_rst = 1; @(posedge clock); #1;
    chk("casc_reset_sec", int'(s_q), 0);
    chk("casc_reset_min", int'(m_q), 0);
    c_rst = 0; c_en = 1;
    for (int k = 1; k <= 3601; k++) begin
      @(posedge clock); #1;
      chk("casc_sec", int'(s_q), k % 60);
      chk("casc_sec_bcd", int'(s_t) * 10 + int'(s_o), k % 60);
      chk("casc_min", int'(m_q), ((k - 1) / 60) % 60);
      chk("casc_min_bcd", int'(m_t) * 10 + int'(m_o), ((k - 1) / 60) % 60);
      chk("casc_sec_carry", int'(s_c), int'(k % 60 == 0));
      chk("casc_min_carry", int'(m_c), int'(k > 1 && (k - 1) % 3600 == 0));
      if (k == 3599) chk("casc_min59", int'(m_q), 59);
      if (k == 3601) chk("casc_min_wrap_carry", int'(m_c), 1);
    end
    c_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
